// File: rtl/ipd_accion.sv
// Servo control-action stage: combines the I/P/D terms into a saturated duty,
// applies integral anti-windup and drives a glitch-free PWM output.
module ipd_accion #(
  parameter int ancho = 20,
  parameter int UMAX  = 255,
  parameter int PRESC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    IPDready,
  input  logic signed [ancho-1:0] Integral,
  input  logic signed [ancho-1:0] Proporcional,
  input  logic signed [ancho-1:0] Derivada,
  input  logic signed [ancho-1:0] yk,
  output logic signed [ancho-1:0] i1,
  output logic signed [ancho-1:0] yk1,
  output logic        [7:0]       uk,
  output logic                    uk_valid,
  output logic                    sat_hi,
  output logic                    sat_lo,
  output logic                    overrun,
  output logic                    busy,
  output logic                    pwm_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUM  = 2'd1;
  localparam logic [1:0] S_SAT  = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;

  localparam int SW = ancho + 2;
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic signed [SW-1:0] UMAX_S = SW'(UMAX);
  localparam logic        [7:0]    UMAX_U = 8'(UMAX);
  localparam logic        [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [1:0]              state_q, state_d;
  logic signed [ancho-1:0] intg_q, intg_d, prop_q, prop_d, der_q, der_d, ykc_q, ykc_d;
  logic signed [SW-1:0]    s_q, s_d;
  logic [7:0]              ukSat_q, ukSat_d;
  logic                    hiN_q, hiN_d, loN_q, loN_d;
  logic [7:0]              uk_q, uk_d;
  logic signed [ancho-1:0] i1_q, i1_d, yk1_q, yk1_d;
  logic                    ukv_q, ukv_d, sh_q, sh_d, sl_q, sl_d, ovr_q, ovr_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [7:0]              cnt_q, cnt_d, duty_q, duty_d;
  logic                    pwm_q, pwm_d;
  logic                    tick;
  logic                    holdI;

  // Anti-windup: never let the integral grow further into the saturated side.
  assign holdI = (hiN_q && (intg_q > i1_q)) || (loN_q && (intg_q < i1_q));

  always_comb begin
    state_d = state_q;
    intg_d  = intg_q;
    prop_d  = prop_q;
    der_d   = der_q;
    ykc_d   = ykc_q;
    s_d     = s_q;
    ukSat_d = ukSat_q;
    hiN_d   = hiN_q;
    loN_d   = loN_q;
    uk_d    = uk_q;
    i1_d    = i1_q;
    yk1_d   = yk1_q;
    sh_d    = sh_q;
    sl_d    = sl_q;
    ukv_d   = 1'b0;
    ovr_d   = ovr_q | (IPDready && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (IPDready) begin
          intg_d  = Integral;
          prop_d  = Proporcional;
          der_d   = Derivada;
          ykc_d   = yk;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        s_d     = SW'(intg_q) - SW'(prop_q) - SW'(der_q);
        state_d = S_SAT;
      end
      S_SAT: begin
        if (s_q > UMAX_S) begin
          ukSat_d = UMAX_U;
          hiN_d   = 1'b1;
          loN_d   = 1'b0;
        end else if (s_q[SW-1]) begin
          ukSat_d = 8'd0;
          hiN_d   = 1'b0;
          loN_d   = 1'b1;
        end else begin
          ukSat_d = s_q[7:0];
          hiN_d   = 1'b0;
          loN_d   = 1'b0;
        end
        state_d = S_LOAD;
      end
      S_LOAD: begin
        uk_d    = ukSat_q;
        sh_d    = hiN_q;
        sl_d    = loN_q;
        yk1_d   = ykc_q;
        if (!holdI) i1_d = intg_q;
        ukv_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Duty is sampled from the next-state uk so an update on the wrap edge lands in the new period.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
    duty_d  = (tick && (cnt_q == 8'hFF)) ? uk_d : duty_q;
    pwm_d   = (cnt_d < duty_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      intg_q  <= '0;
      prop_q  <= '0;
      der_q   <= '0;
      ykc_q   <= '0;
      s_q     <= '0;
      ukSat_q <= '0;
      hiN_q   <= 1'b0;
      loN_q   <= 1'b0;
      uk_q    <= '0;
      i1_q    <= '0;
      yk1_q   <= '0;
      ukv_q   <= 1'b0;
      sh_q    <= 1'b0;
      sl_q    <= 1'b0;
      ovr_q   <= 1'b0;
      presc_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      intg_q  <= intg_d;
      prop_q  <= prop_d;
      der_q   <= der_d;
      ykc_q   <= ykc_d;
      s_q     <= s_d;
      ukSat_q <= ukSat_d;
      hiN_q   <= hiN_d;
      loN_q   <= loN_d;
      uk_q    <= uk_d;
      i1_q    <= i1_d;
      yk1_q   <= yk1_d;
      ukv_q   <= ukv_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      ovr_q   <= ovr_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  assign i1       = i1_q;
  assign yk1      = yk1_q;
  assign uk       = uk_q;
  assign uk_valid = ukv_q;
  assign sat_hi   = sh_q;
  assign sat_lo   = sl_q;
  assign overrun  = ovr_q;
  assign busy     = (state_q != S_IDLE);
  assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_ipd_accion.sv
// Bench for ipd_accion: two instances (PRESC=1 and PRESC=4) checked against an
// arithmetic reference of the control law and a time-based PWM model.
module tb_ipd_accion;

  localparam int W = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic IPDready = 1'b0;
  logic signed [W-1:0] Integral = '0, Proporcional = '0, Derivada = '0, yk = '0;

  logic signed [W-1:0] i1A, yk1A, i1B, yk1B;
  logic [7:0] ukA, ukB;
  logic ukvA, shA, slA, ovA, busyA, pwmA;
  logic ukvB, shB, slB, ovB, busyB, pwmB;

  ipd_accion #(.ancho(W), .UMAX(255), .PRESC(1)) dutA (
    .clk(clk), .rst_n(rst_n), .IPDready(IPDready),
    .Integral(Integral), .Proporcional(Proporcional), .Derivada(Derivada), .yk(yk),
    .i1(i1A), .yk1(yk1A), .uk(ukA), .uk_valid(ukvA), .sat_hi(shA), .sat_lo(slA),
    .overrun(ovA), .busy(busyA), .pwm_out(pwmA));

  ipd_accion #(.ancho(W), .UMAX(255), .PRESC(4)) dutB (
    .clk(clk), .rst_n(rst_n), .IPDready(IPDready),
    .Integral(Integral), .Proporcional(Proporcional), .Derivada(Derivada), .yk(yk),
    .i1(i1B), .yk1(yk1B), .uk(ukB), .uk_valid(ukvB), .sat_hi(shB), .sat_lo(slB),
    .overrun(ovB), .busy(busyB), .pwm_out(pwmB));

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;
  int edgeCnt = 0;
  int mUk = 0, mDutyA = 0, mDutyB = 0;
  int pendEdge = -1, pendUk = 0;
  int mI1 = 0;

  // PWM reference: cnt = floor(edges/PRESC) mod 256, duty reloaded at each period boundary.
  always @(posedge clk or negedge rst_n) begin
    int u;
    if (!rst_n) begin
      edgeCnt <= 0;
      mUk     <= 0;
      mDutyA  <= 0;
      mDutyB  <= 0;
    end else begin
      u = (edgeCnt + 1 == pendEdge) ? pendUk : mUk;
      mUk <= u;
      if ((edgeCnt + 1) % 256 == 0) mDutyA <= u;
      if ((edgeCnt + 1) % 1024 == 0) mDutyB <= u;
      edgeCnt <= edgeCnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic checkPwm(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("pwmA", 64'(pwmA), 64'(((edgeCnt % 256) < mDutyA) ? 1 : 0));
      checkOutput("pwmB", 64'(pwmB), 64'((((edgeCnt / 4) % 256) < mDutyB) ? 1 : 0));
    end
  endtask

  // Called at a falling edge; leaves time at the falling edge after uk_valid appears.
  task automatic applyStimulus(input int I, input int P, input int D, input int Y,
                               input bit probeOverrun);
    int s, u, nI1;
    bit h, l;
    s = I - P - D;
    h = 1'b0;
    l = 1'b0;
    if (s > 255) begin u = 255; h = 1'b1; end
    else if (s < 0) begin u = 0; l = 1'b1; end
    else u = s;
    nI1 = ((h && I > mI1) || (l && I < mI1)) ? mI1 : I;
    pendUk   = u;
    pendEdge = edgeCnt + 4;
    Integral = W'(I);
    Proporcional = W'(P);
    Derivada = W'(D);
    yk = W'(Y);
    IPDready = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_strobe", 64'(busyA), 64'(1));
    if (probeOverrun) begin
      Integral = W'(777);
      Proporcional = W'(-3);
      Derivada = W'(1);
      yk = W'(-55);
    end else begin
      IPDready = 1'b0;
    end
    @(negedge clk);
    IPDready = 1'b0;
    if (probeOverrun) checkOutput("overrun_set", 64'(ovA), 64'(1));
    @(negedge clk);
    checkOutput("uk_valid_early", 64'(ukvA), 64'(0));
    @(negedge clk);
    checkOutput("uk_valid", 64'(ukvA), 64'(1));
    checkOutput("uk", 64'(ukA), 64'(u));
    checkOutput("sat_hi", 64'(shA), 64'(h));
    checkOutput("sat_lo", 64'(slA), 64'(l));
    checkOutput("i1", 64'(i1A), 64'(nI1));
    checkOutput("yk1", 64'(yk1A), 64'(Y));
    checkOutput("busy_done", 64'(busyA), 64'(0));
    checkOutput("ukB", 64'(ukB), 64'(u));
    checkOutput("i1B", 64'(i1B), 64'(nI1));
    mI1 = nI1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_uk"}, 64'(ukA), 64'(0));
    checkOutput({tag, "_i1"}, 64'(i1A), 64'(0));
    checkOutput({tag, "_yk1"}, 64'(yk1A), 64'(0));
    checkOutput({tag, "_uk_valid"}, 64'(ukvA), 64'(0));
    checkOutput({tag, "_sat_hi"}, 64'(shA), 64'(0));
    checkOutput({tag, "_sat_lo"}, 64'(slA), 64'(0));
    checkOutput({tag, "_overrun"}, 64'(ovA), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busyA), 64'(0));
    checkOutput({tag, "_pwmA"}, 64'(pwmA), 64'(0));
    checkOutput({tag, "_pwmB"}, 64'(pwmB), 64'(0));
    checkOutput({tag, "_ukB"}, 64'(ukB), 64'(0));
  endtask

  initial begin
    int highs;
    int I, P, D, Y;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    checkPwm(3);

    // Nominal, saturation high with anti-windup, saturation low.
    applyStimulus(300, 100, 50, 7, 1'b0);
    applyStimulus(500, 400, 0, -12, 1'b0);
    applyStimulus(1000, 0, 0, 33, 1'b0);
    applyStimulus(400, 0, 0, 34, 1'b0);
    applyStimulus(10, 100, 0, 35, 1'b0);
    checkPwm(300);

    // Mid-period duty change must only show in the following period.
    for (int k = 0; k < 300 && (edgeCnt % 256) != 100; k++) checkPwm(1);
    applyStimulus(64, 0, 0, 5, 1'b0);
    for (int k = 0; k < 300 && (edgeCnt % 256) != 255; k++) checkPwm(1);
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      checkPwm(1);
      highs += (pwmA === 1'b1) ? 1 : 0;
    end
    checkOutput("pwm_high_count", 64'(highs), 64'(64));

    // Strobe during SUM is dropped and flagged.
    applyStimulus(200, 50, 20, 9, 1'b1);
    checkPwm(2);

    // Randomized back-to-back and gapped updates.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        I = int'($urandom_range(0, 700)) - 100;
        P = int'($urandom_range(0, 300));
        D = int'($urandom_range(0, 200)) - 100;
      end else begin
        I = int'($urandom_range(0, 400000)) - 200000;
        P = int'($urandom_range(0, 400000)) - 200000;
        D = int'($urandom_range(0, 400000)) - 200000;
      end
      Y = int'($urandom_range(0, 1000)) - 500;
      applyStimulus(I, P, D, Y, 1'b0);
      checkPwm(int'($urandom_range(0, 3)));
    end
    checkOutput("overrun_sticky", 64'(ovA), 64'(1));
    checkPwm(1100);

    // Reset while the update sits in SAT.
    Integral = W'(300);
    Proporcional = W'(100);
    Derivada = W'(50);
    yk = W'(3);
    IPDready = 1'b1;
    @(negedge clk);
    IPDready = 1'b0;
    @(negedge clk);
    pendEdge = -1;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mI1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("no_valid_after_abort", 64'(ukvA), 64'(0));
    end
    applyStimulus(300, 100, 50, 7, 1'b0);
    checkPwm(1100);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/ipd_accion.md
IPD_ACCION -- requirements
Module: ipd_accion

Interface
REQ-001 SHALL have parameter ancho, default 20, width of signed term, integral-state and sample buses.
REQ-002 SHALL have parameter UMAX, default 255, upper clamp of control action (duty counts).
REQ-003 SHALL have parameter PRESC, default 4, clk cycles per PWM counter tick (>=1).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port IPDready  input  1  one-cycle strobe: Integral/Proporcional/Derivada valid.
REQ-007 SHALL have ports Integral, Proporcional, Derivada  input  ancho  signed two's-complement controller terms.
REQ-008 SHALL have port yk  input  ancho  current sample, latched with the terms.
REQ-009 SHALL have port i1  output  ancho  integral state fed back to the term calculator.
REQ-010 SHALL have port yk1  output  ancho  previous sample fed back to the term calculator.
REQ-011 SHALL have port uk  output  8  saturated control action (duty).
REQ-012 SHALL have port uk_valid  output  1  one-cycle strobe, uk/i1/yk1 updated.
REQ-013 SHALL have ports sat_hi, sat_lo  output  1  last update was clamped to UMAX / to 0.
REQ-014 SHALL have port overrun  output  1  sticky: IPDready arrived while busy.
REQ-015 SHALL have port busy  output  1  FSM not in IDLE.
REQ-016 SHALL have port pwm_out  output  1  servo PWM drive.

Function
REQ-017 SHALL implement FSM IDLE -> SUM -> SAT -> LOAD -> IDLE, one state per clock, unconditional after leaving IDLE.
REQ-018 SHALL leave IDLE only on IPDready=1, capturing Integral, Proporcional, Derivada, yk on that edge (E0).
REQ-019 SHALL in SUM compute s = Integral - Proporcional - Derivada sign-extended to ancho+2 bits (no overflow).
REQ-020 SHALL in SAT clamp: s>UMAX -> UMAX, sat_hi; s<0 -> 0, sat_lo; else s, both flags 0.
REQ-021 SHALL in LOAD register uk, sat_hi, sat_lo, yk1<=captured yk, i1 per REQ-022; uk_valid=1 exactly the cycle after edge E3 (latency 3 edges after E0).
REQ-022 SHALL anti-windup: hold i1 if (sat_hi and captured Integral > i1) or (sat_lo and captured Integral < i1), signed compare; otherwise i1<=captured Integral.
REQ-023 SHALL ignore IPDready when busy=1 and set overrun=1; overrun clears only on reset.
REQ-024 SHALL accept IPDready in the cycle after LOAD (FSM back in IDLE); back-to-back strobes 4 cycles apart all accepted.
REQ-025 SHALL hold uk, i1, yk1, sat flags between updates.
REQ-026 SHALL run an 8-bit PWM counter cnt incremented once every PRESC clk cycles, wrapping 255->0 (period 256*PRESC clk).
REQ-027 SHALL drive pwm_out=1 iff cnt < duty_act (registered), so duty 0 -> always 0, duty 255 -> 255/256 high.
REQ-028 SHALL load duty_act<=uk only on the tick where cnt wraps to 0; a uk change mid-period takes effect next period, never glitching the current one.
REQ-029 SHALL, if uk_valid and the wrap tick coincide, load the new uk into duty_act on that tick.

Reset
REQ-030 SHALL on rst_n=0, immediately and regardless of clk: FSM IDLE, uk=0, i1=0, yk1=0, uk_valid=0, sat_hi=0, sat_lo=0, overrun=0, busy=0, cnt=0, prescaler=0, duty_act=0, pwm_out=0.
REQ-031 SHALL abort an in-progress update on reset mid-operation with no uk_valid pulse; first IPDready after rst_n deasserts is processed normally.

Verification
REQ-032 SHALL pass: I=300,P=100,D=50 strobed -> uk=150, uk_valid 3 edges later, sat flags 0, i1=300.
REQ-033 SHALL pass: i1=500, I=1000,P=0,D=0 -> uk=255, sat_hi=1, i1 stays 500; then I=400 (s=400) -> uk=255, i1=400.
REQ-034 SHALL pass: I=10,P=100,D=0 -> s=-90, uk=0, sat_lo=1, pwm_out constant 0 next period.
REQ-035 SHALL pass: PRESC=1, uk=64 loaded mid-period -> current period unchanged, next period pwm_out high exactly 64 of 256 clk.
REQ-036 SHALL pass: IPDready during SUM -> overrun=1, second strobe ignored, first result delivered unchanged.
REQ-037 SHALL pass: rst_n low during SAT -> no uk_valid, all outputs 0; strobe after release gives correct uk.
